// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected accesses.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wen,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   ZERO_CNT = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   count_nxt_s;
   logic [DATA_WIDTH-1:0] data_out_r;
   logic                  full_r;
   logic                  empty_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  rd_ok_s;
   logic                  wr_ok_s;

   // Acceptance decisions and next occupancy, from pre-edge state.
   // A full FIFO can still take a write when a read frees a slot this cycle.
   always_comb begin
      rd_ok_s     = 1'b0;
      wr_ok_s     = 1'b0;
      count_nxt_s = count_r;
      rd_ok_s     = ren & ~empty_r;
      wr_ok_s     = wen & (~full_r | rd_ok_s);
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_nxt_s = count_r + ONE_CNT;
         2'b01:   count_nxt_s = count_r - ONE_CNT;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array; never cleared, and reset blocks writes in its cycle.
   always_ff @(posedge clk) begin
      if (rst && wr_ok_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Pointers, count, flags and read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
         count_r     <= ZERO_CNT;
         full_r      <= 1'b0;
         empty_r     <= 1'b1;
         data_out_r  <= {DATA_WIDTH{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (rd_ok_s) begin
            rd_ptr_r   <= rd_ptr_r + ONE_PTR;
            data_out_r <= mem_r[rd_ptr_r];
         end
         count_r     <= count_nxt_s;
         full_r      <= (count_nxt_s == FULL_CNT);
         empty_r     <= (count_nxt_s == ZERO_CNT);
         overflow_r  <= wen & ~wr_ok_s;
         underflow_r <= ren & ~rd_ok_s;
      end
   end

   assign data_out  = data_out_r;
   assign full      = full_r;
   assign empty     = empty_r;
   assign count     = count_r;
   assign overflow  = overflow_r;
   assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for the basic behaviour plus
// hand-written sequences for fill/overflow, full pass-through, wrap and reset.
module tb_sync_fifo;

   logic       tb_clk;
   logic       rst;
   logic [7:0] data_in;
   logic       wen;
   logic       ren;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_tests;
   int n_fail;

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk       (tb_clk),
      .rst       (rst),
      .data_in   (data_in),
      .wen       (wen),
      .ren       (ren),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   typedef struct {
      logic       rst;
      logic       wen;
      logic       ren;
      logic [7:0] din;
      int         cycles;
      logic [7:0] exp_do;
      logic [4:0] exp_cnt;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ov;
      logic       exp_un;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_do, input logic [4:0] e_cnt,
                            input logic e_full, input logic e_empty, input logic e_ov, input logic e_un);
      check({tag, ".data_out"},  32'(data_out),  32'(e_do));
      check({tag, ".count"},     32'(count),     32'(e_cnt));
      check({tag, ".full"},      32'(full),      32'(e_full));
      check({tag, ".empty"},     32'(empty),     32'(e_empty));
      check({tag, ".overflow"},  32'(overflow),  32'(e_ov));
      check({tag, ".underflow"}, 32'(underflow), 32'(e_un));
   endtask

   task automatic drive(input logic r, input logic w, input logic rd, input logic [7:0] d);
      rst     = r;
      wen     = w;
      ren     = rd;
      data_in = d;
      @(posedge tb_clk);
      #1;
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] exp_do;
      logic       w, r, rd_ok, wr_ok;

      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0; wen = 1'b0; ren = 1'b0; data_in = 8'h00;

      //               rst   wen   ren   din   cyc exp_do cnt    full  empty ov    un
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h5A, 1, 8'hAA, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h5A, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1, 8'h5A, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h33, 1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h33, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};

      for (int i = 0; i < 15; i++) begin
         for (int c = 0; c < vecs[i].cycles; c++) begin
            drive(vecs[i].rst, vecs[i].wen, vecs[i].ren, vecs[i].din);
         end
         check_all($sformatf("vec%0d", i), vecs[i].exp_do, vecs[i].exp_cnt,
                   vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_ov, vecs[i].exp_un);
      end

      // Fill to 16 words, then a rejected write.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(i));
         check($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
      end
      check_all("full", 8'h00, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'hFF);
      check_all("ovf", 8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      check_all("ovf_end", 8'h00, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);

      // Simultaneous write and read while full: oldest word out, count steady.
      drive(1'b1, 1'b1, 1'b1, 8'h10);
      check_all("full_rw", 8'h00, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);

      // Drain: 01..0F then 10; FF must never appear.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'h00);
         check($sformatf("drain%0d.data_out", i), 32'(data_out), 32'(i));
         check($sformatf("drain%0d.count", i), 32'(count), 32'(16 - i));
      end
      check_all("drained", 8'h10, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Interleaved traffic across the pointer wrap, against a queue model.
      exp_do = 8'h10;
      for (int k = 0; k < 40; k++) begin
         w     = (k % 2 == 0) || (k % 5 == 1);
         r     = (k % 2 == 1);
         rd_ok = r && (q.size() > 0);
         wr_ok = w && ((q.size() < 16) || rd_ok);
         if (rd_ok) exp_do = q.pop_front();
         if (wr_ok) q.push_back(8'(k * 7 + 3));
         drive(1'b1, w, r, 8'(k * 7 + 3));
         check($sformatf("wrap%0d.data_out", k), 32'(data_out), 32'(exp_do));
         check($sformatf("wrap%0d.count", k), 32'(count), 32'(q.size()));
      end

      // Top up to five stored words, then reset mid-run.
      drive(1'b1, 1'b1, 1'b0, 8'hC5);
      check("pre_rst.count", 32'(count), 32'd5);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check_all("mid_rst", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      check_all("post_rst_rd", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
